vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumes the 36 MHz `vga_clk` and the PLL `lock` flag produced by the PLL wrapper, and generates VGA raster timing for 800x600 at 56 Hz (VESA, 36 MHz).
- Outputs are hsync, vsync, data-enable and pixel coordinates.
- Gates all timing on a synchronised, debounced PLL lock, so downstream pixel logic never runs on an unstable clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 72, hsync pulse width (pixels)
- H_BACK, 128, horizontal back porch (pixels); H_TOTAL = 1024
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 22, vertical back porch (lines); V_TOTAL = 625
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- SETTLE_CYCLES, 1024, cycles `lock` must stay high before the raster starts
- CW, 11, width of the coordinate and counter registers

Ports:
- vga_clk  in  1  pixel clock, 36 MHz; the single clock of the block
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  PLL lock flag; treated as asynchronous to `vga_clk`
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- de  out  1  high while (pix_x, pix_y) is in the visible area
- pix_x  out  CW  horizontal counter, 0..H_TOTAL-1
- pix_y  out  CW  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse at pix_x == 0
- frame_start  out  1  one-cycle pulse at pix_x == 0 and pix_y == 0
- running  out  1  high while the FSM is in RUN

Behaviour:
- **Lock synchroniser:** `pll_lock` passes through 2 flops to give `lock_s`. Both flops clear on `rst`.
- **FSM states:** WAIT_LOCK, SETTLE, RUN. Reset state is WAIT_LOCK.
- **WAIT_LOCK:**
  - Settle counter = 0, h_cnt = 0, v_cnt = 0.
  - Moves to SETTLE when lock_s = 1.
- **SETTLE:**
  - Settle counter increments each cycle.
  - lock_s = 0 returns to WAIT_LOCK and clears the counter.
  - When the counter reaches SETTLE_CYCLES-1 with lock_s still 1, moves to RUN with h_cnt = 0 and v_cnt = 0.
- **RUN (counting):**
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- **RUN (lock loss):** lock_s = 0 sends the FSM to WAIT_LOCK on the next edge. The raster is abandoned mid-frame, with no completion of the current line or frame.
- **Decode:**
  - de_c = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync_c is active when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, i.e. 824..895.
  - vsync_c is active when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, i.e. 601..602.
  - vsync changes on the same cycle as hsync edges are evaluated; there is no half-line offset.
- **Output registers:**
  - All outputs are registered and mutually aligned.
  - Each output reflects the h_cnt/v_cnt state of the previous cycle (1-cycle latency).
  - pix_x and pix_y are the registered copies of h_cnt and v_cnt.
- **Idle / reset output values:** outside RUN, and on rst:
  - hsync = ~H_POL, vsync = ~V_POL
  - de = 0, line_start = 0, frame_start = 0, running = 0
  - pix_x = 0, pix_y = 0
- **First RUN cycle:** the first registered RUN output shows pix_x = 0, pix_y = 0, de = 1, line_start = 1, frame_start = 1, running = 1.
- **rst priority:** rst has priority over everything. A reset mid-frame returns to WAIT_LOCK and idle outputs on the next edge. The synchroniser is cleared, so lock must be re-sampled (2 cycles) and re-settled.
- **Counter widths:** all counters are CW bits and must not overflow. Generics must satisfy H_TOTAL, V_TOTAL <= 2^CW.
- **Boundary cases:**
  - A lock glitch shorter than the settle window restarts SETTLE from 0.
  - lock_s falling on the same cycle the settle count completes means no RUN; the FSM goes to WAIT_LOCK.

Test Plan:
1. **Lock start-up:** rst for 4 cycles, pll_lock = 1 from cycle 10.
   - running = 0 until lock_s (cycle 12) + 1024 settle cycles, then running = 1.
   - First output: frame_start = 1, pix_x = 0, pix_y = 0, de = 1.
2. **Line timing:** in RUN, measure one line.
   - de high for exactly 800 cycles per visible line.
   - hsync high for 72 cycles starting at pix_x = 824.
   - line_start period = 1024 cycles.
3. **Frame timing:** run 2 full frames.
   - frame_start period = 640000 cycles.
   - vsync high for 2048 cycles, beginning at pix_y = 601, pix_x = 0.
   - de never high for pix_y >= 600.
4. **Glitch in SETTLE:** drop pll_lock for 3 cycles midway through SETTLE.
   - Settle restarts; running rises only 1024 cycles after lock_s returns high.
5. **Lock loss mid-frame:** drop pll_lock at pix_y = 300.
   - Two sync cycles after the drop, running = 0, de = 0, hsync = vsync = 0, pix_x = pix_y = 0.
   - On re-lock, the block re-settles and restarts at frame_start.
6. **Reset mid-frame:** assert rst for 1 cycle at pix_x = 500, pix_y = 100.
   - Idle outputs appear on the next edge.
   - Recovery takes 2 sync cycles + 1024 settle cycles with pll_lock held at 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@56Hz VGA raster timing gated on a synchronised, settled PLL lock
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT = 24,
  parameter int H_SYNC = 72,
  parameter int H_BACK = 128,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT = 1,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 22,
  parameter logic H_POL = 1'b1,
  parameter logic V_POL = 1'b1,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CW = 11
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic          pll_lock,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] settle_q, settle_d, h_q, h_d, v_q, v_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d, running_q, running_d;
  logic lock_s, run;

  assign lock_s = sync_q[1];
  assign run = state_q == RUN;

  // next state and raster counters; counters stay cleared outside RUN
  always_comb begin
    sync_d = {sync_q[0], pll_lock};
    state_d = state_q;
    settle_d = '0;
    h_d = '0;
    v_d = '0;
    case (state_q)
      WAIT_LOCK: state_d = lock_s ? SETTLE : WAIT_LOCK;
      SETTLE: begin
        state_d = !lock_s ? WAIT_LOCK : (settle_q == S_LAST) ? RUN : SETTLE;
        settle_d = (lock_s && settle_q != S_LAST) ? settle_q + 1'b1 : '0;
      end
      RUN: begin
        state_d = lock_s ? RUN : WAIT_LOCK;
        h_d = (!lock_s || h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = !lock_s ? '0 : (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // decode of the current counters into the next registered outputs
  always_comb begin
    de_d = run && h_q < H_ACT && v_q < V_ACT;
    hsync_d = (run && h_q >= HS_BEG && h_q < HS_END) ? H_POL : ~H_POL;
    vsync_d = (run && v_q >= VS_BEG && v_q < VS_END) ? V_POL : ~V_POL;
    line_start_d = run && h_q == '0;
    frame_start_d = run && h_q == '0 && v_q == '0;
    running_d = run;
    pix_x_d = h_q;
    pix_y_d = v_q;
  end

  // state, synchroniser, counters and output registers
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      sync_q <= '0;
      settle_q <= '0;
      h_q <= '0;
      v_q <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q <= 1'b0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      running_q <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      settle_q <= settle_d;
      h_q <= h_d;
      v_q <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q <= de_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q <= running_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de = de_q;
  assign line_start = line_start_q;
  assign frame_start = frame_start_q;
  assign running = running_q;
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
endmodule
